mod_n_pwm_generator: RTL and testbench
======================================

Name: mod_n_pwm_generator

Overview:
Downstream consumer of the modulo-N counter. Samples the counter's free-running count `q` and produces a PWM waveform, a period-start tick and a duty-cycle load handshake. Duty updates are double-buffered and take effect only at a counter wrap, so no glitched period is ever emitted. Start and stop are aligned to period boundaries.

Parameters:
N, 4, width of the counter value `q_in`; must match the upstream counter width.
MOD, 16, counter modulus; `q_in` cycles 0..MOD-1. Legal range is 2 <= MOD <= 2^N.

Ports:
clock  input  1  single clock, rising edge.
clear  input  1  synchronous, active-high reset.
q_in  input  N  count value from the modulo-N counter.
enable  input  1  request to run PWM output; level-sensitive.
duty_in  input  N+1  requested high time in counts, 0..2^(N+1)-1.
duty_valid  input  1  duty_in is offered.
duty_ready  output  1  block can accept a duty value; combinational, equal to !pending.
pwm_out  output  1  registered PWM output.
period_tick  output  1  registered one-cycle pulse at the start of each driven period.
running  output  1  high in states RUN and STOPPING.

Behaviour:
- Clock and reset: one clock (`clock`). Reset (`clear`) is synchronous and active-high.
- Reset values, applied on the edge where clear=1:
  - state=IDLE, prev_q=0, prev_valid=0, pending=0, pend_duty=0, active_duty=0.
  - pwm_out=0, period_tick=0, running=0, so duty_ready=1.
  - clear mid-operation discards any pending duty; it has priority over all other events.
- Wrap detect (combinational):
  - wrap = prev_valid && (q_in==0) && (prev_q!=0).
  - prev_q<=q_in and prev_valid<=1 every non-reset cycle.
  - If the counter stalls at 0, only one wrap is generated.
- Duty intake:
  - Accept when duty_valid && duty_ready.
  - On accept: pend_duty <= min(duty_in, MOD); pending<=1.
  - A value accepted in a wrap cycle is NOT applied at that wrap; it applies at the next one.
  - At a wrap with pending=1 (and no accept in that cycle): active_duty<=pend_duty, pending<=0.
  - The new duty governs the compare in that same wrap cycle.
  - Define eff_duty = (wrap && pending) ? pend_duty : active_duty.
- FSM:
  - IDLE: enable=1 -> ARMED. pwm_out stays 0.
  - ARMED: enable=0 -> IDLE. wrap -> RUN. pwm_out=0 while waiting.
  - RUN: enable=0 (checked every cycle) -> STOPPING. Otherwise stay in RUN.
  - STOPPING: enable=1 -> RUN with no gap. wrap with enable=0 -> IDLE; the period completes fully before output drops.
  - Simultaneous wrap and enable=1 in STOPPING -> RUN.
- Outputs (registered, one cycle latency from q_in):
  - pwm_out <= (next state in {RUN, STOPPING}) && (q_in < eff_duty).
  - duty=0 gives constant 0. duty>=MOD (clamped to MOD) gives constant 1.
  - period_tick <= wrap && enable && (state in {ARMED, RUN, STOPPING}).
  - running <= next state in {RUN, STOPPING}.
- Upstream pre-clear: while the upstream counter is held in clear, q_in==0 persists and no wrap occurs.

Test Plan:
1. Reset, N=4, MOD=16: clear=1 for 2 cycles, enable=0 -> pwm_out=0, period_tick=0, running=0, duty_ready=1.
2. Basic run: load duty 4, enable=1, counter free-running 0..15 -> ARMED until the first q_in 15->0; then pwm_out high for 4 cycles (q 0..3, seen one cycle later), low for 12; period_tick pulses every 16 cycles coincident with pwm rise.
3. Mid-period update: running at duty 4, offer duty 10 at q=7 -> duty_ready=0 until next wrap. Current period high for 4 counts; next period high for 10; duty_ready returns to 1 the cycle after the wrap.
4. Saturation: duty 0 -> pwm_out constant 0 with period_tick still pulsing. Duty 20 -> clamped to 16, pwm_out constant 1.
5. Stop/restart: enable=0 at q=2 -> period finishes per duty, IDLE after the wrap, pwm_out=0, running=0. Repeat with enable re-asserted at q=9 -> output continuous, no missing period.
6. Reset mid-run: clear=1 at q=5 with a pending duty -> next cycle all outputs 0, duty_ready=1. After release with enable=1, the block waits in ARMED for a wrap; active_duty=0, so pwm_out stays 0.

Source files
------------

// File: rtl/mod_n_pwm_generator_if.sv
// Duty-cycle load handshake between a duty source and the PWM generator.
// The source offers duty_in with duty_valid; the generator answers with
// duty_ready, which is high whenever its single-entry duty buffer is empty.
interface mod_n_pwm_generator_if #(
  parameter int N = 4
);

  logic [N:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;

  // Duty source side
  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  // PWM generator side
  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/mod_n_pwm_generator.sv
// PWM generator driven by the free-running count of an upstream modulo-MOD
// counter. A wrap of the count (non-zero -> zero) marks a period boundary.
// Duty values are double-buffered: an accepted value waits in pend_duty and
// is promoted to active_duty only at a wrap, so every emitted period uses a
// single duty value. Start and stop are aligned to period boundaries.
module mod_n_pwm_generator #(
  parameter int N   = 4,
  parameter int MOD = 16
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic [N-1:0]                q_in,
  input  logic                        enable,
  mod_n_pwm_generator_if.slave        duty_if,
  output logic                        pwm_out,
  output logic                        period_tick,
  output logic                        running
);

  // Duty saturation value; MOD <= 2^N always fits in N+1 bits.
  localparam logic [N:0] MOD_W = (N+1)'(MOD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [N-1:0] prev_q;
  logic         prev_valid;
  logic         pending;
  logic [N:0]   pend_duty;
  logic [N:0]   active_duty;

  logic         wrap;
  logic         accept;
  logic [N:0]   duty_clamped;
  logic [N:0]   eff_duty;
  logic         driving_nxt;
  logic         tick_nxt;
  logic         pwm_nxt;

  // The buffer takes a new value only while empty.
  assign duty_if.duty_ready = !pending;

  // Period-boundary detect, duty intake qualification and the duty that
  // governs this cycle's compare (a wrap promotes the pending value at once).
  always_comb begin
    wrap         = prev_valid && (q_in == '0) && (prev_q != '0);
    accept       = duty_if.duty_valid && !pending;
    duty_clamped = (duty_if.duty_in > MOD_W) ? MOD_W : duty_if.duty_in;
    eff_duty     = (wrap && pending) ? pend_duty : active_duty;
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_nxt   = state;
    driving_nxt = 1'b0;
    tick_nxt    = 1'b0;
    pwm_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable)   state_nxt = IDLE;
        else if (wrap) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (enable)    state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    driving_nxt = (state_nxt == RUN) || (state_nxt == STOPPING);
    tick_nxt    = wrap && enable && (state != IDLE);
    pwm_nxt     = driving_nxt && ({1'b0, q_in} < eff_duty);
  end

  // State register, wrap-detect history, duty buffers and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before this edge, regardless of statement order.
    if (clear) begin
      state       <= IDLE;
      prev_q      <= '0;
      prev_valid  <= 1'b0;
      pending     <= 1'b0;
      pend_duty   <= '0;
      active_duty <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      running     <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_q     <= q_in;
      prev_valid <= 1'b1;

      if (accept) begin
        pend_duty <= duty_clamped;
        pending   <= 1'b1;
      end else if (wrap && pending) begin
        active_duty <= pend_duty;
        pending     <= 1'b0;
      end

      pwm_out     <= pwm_nxt;
      period_tick <= tick_nxt;
      running     <= driving_nxt;
    end
  end

endmodule

// File: tb/tb_mod_n_pwm_generator.sv
// Self-checking bench for mod_n_pwm_generator. The bench plays the upstream
// counter (with stalls and upstream pre-clear), drives enable and the duty
// handshake, and keeps a behavioural model of the period/duty rules. Each
// clock edge the model's expected outputs are queued; an independent monitor
// pops and compares them half a cycle later.
module tb_mod_n_pwm_generator;

  localparam int N   = 4;
  localparam int MOD = 16;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic [N-1:0] q_in  = '0;
  logic         enable = 1'b0;
  logic         pwm_out;
  logic         period_tick;
  logic         running;

  mod_n_pwm_generator_if #(.N(N)) dif ();

  mod_n_pwm_generator #(.N(N), .MOD(MOD)) dut (
    .clock       (clock),
    .clear       (clear),
    .q_in        (q_in),
    .enable      (enable),
    .duty_if     (dif.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .running     (running)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pwm;
    logic tick;
    logic run;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state
  int m_prev_q;
  bit m_seen;        // a count has been observed since reset
  bit m_pending;
  int m_pend;
  int m_active;
  bit m_armed;       // waiting for the first boundary
  bit m_driving;     // output is being driven this period
  bit m_prev_en;     // enable as seen on the previous edge

  // Upstream counter controls
  int stall_left = 0;
  bit up_clr     = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: evaluates one clock edge from the current inputs.
  task automatic model(output exp_t e);
    bit boundary, take, drive_n, arm_n, stopping;
    int q, eff, req;
    q = int'(q_in);
    if (clear) begin
      m_prev_q = 0; m_seen = 0; m_pending = 0; m_pend = 0; m_active = 0;
      m_armed = 0; m_driving = 0; m_prev_en = 0;
      e = '{pwm: 1'b0, tick: 1'b0, run: 1'b0, rdy: 1'b1};
      return;
    end
    boundary = m_seen && (q == 0) && (m_prev_q != 0);
    take     = dif.duty_valid && !m_pending;
    eff      = (boundary && m_pending) ? m_pend : m_active;
    // A stop request is one where enable was already low on the prior edge.
    stopping = m_driving && !m_prev_en;
    if (m_driving) drive_n = enable || !(stopping && boundary);
    else           drive_n = m_armed && enable && boundary;
    arm_n = !m_driving && enable && !(m_armed && boundary);

    e.pwm  = drive_n && (q < eff);
    e.tick = boundary && enable && (m_armed || m_driving);
    e.run  = drive_n;

    if (take) begin
      req       = int'(dif.duty_in);
      m_pend    = (req > MOD) ? MOD : req;
      m_pending = 1;
    end else if (boundary && m_pending) begin
      m_active  = m_pend;
      m_pending = 0;
    end
    m_armed   = arm_n;
    m_driving = drive_n;
    m_prev_en = enable;
    m_prev_q  = q;
    m_seen    = 1;
    e.rdy     = !m_pending;
  endtask

  // One clock: model the edge, queue the expectation, advance the counter.
  task automatic step();
    exp_t e;
    int   nq;
    @(posedge clock);
    model(e);
    sb.push_back(e);
    #1;
    if (up_clr) begin
      q_in = '0;
    end else if (stall_left > 0) begin
      stall_left--;
    end else begin
      nq   = (int'(q_in) + 1) % MOD;
      q_in = N'(nq);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int v);
    for (int i = 0; i < 2 * MOD && int'(q_in) != v; i++) step();
  endtask

  task automatic offer(input int d);
    dif.duty_in    = (N+1)'(d);
    dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pwm_out",     int'(pwm_out),        int'(e.pwm));
        check("period_tick", int'(period_tick),    int'(e.tick));
        check("running",     int'(running),        int'(e.run));
        check("duty_ready",  int'(dif.duty_ready), int'(e.rdy));
      end
    end
  end

  // Stimulus
  initial begin
    dif.duty_in    = '0;
    dif.duty_valid = 1'b0;

    // Reset with enable low
    clear = 1'b1;
    run(2);
    clear = 1'b0;

    // Basic run at duty 4
    offer(4);
    enable = 1'b1;
    run(40);

    // Mid-period update to 10 offered at q=7
    run_until(7);
    offer(10);
    run(40);

    // Saturation: duty 0 then duty 20 (clamped to MOD)
    run_until(3);
    offer(0);
    run(40);
    offer(20);
    run(40);

    // Stop at q=2, let the period finish, then restart
    offer(6);
    run(20);
    run_until(2);
    enable = 1'b0;
    run(40);
    enable = 1'b1;
    run(40);
    // Stop at q=2, re-enable at q=9 inside the same period
    run_until(2);
    enable = 1'b0;
    run_until(9);
    enable = 1'b1;
    run(40);

    // Reset at q=5 with a duty pending, then wait for a boundary at duty 0
    run_until(4);
    offer(9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    run(40);

    // Counter stalled at zero and upstream held in clear
    run_until(0);
    stall_left = 6;
    run(30);
    up_clr = 1'b1;
    run(10);
    up_clr = 1'b0;
    run(30);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) enable = ~enable;
      dif.duty_valid = ($urandom_range(5) == 0);
      dif.duty_in    = (N+1)'($urandom_range(2 ** (N + 1) - 1));
      if (stall_left == 0 && $urandom_range(49) == 0) stall_left = int'($urandom_range(5, 1));
      if (!up_clr && $urandom_range(99) == 0) up_clr = 1'b1;
      else if (up_clr && $urandom_range(3) == 0) up_clr = 1'b0;
      clear = ($urandom_range(199) == 0);
      step();
    end
    clear          = 1'b0;
    up_clr         = 1'b0;
    dif.duty_valid = 1'b0;
    run(4);

    @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
